// File: rtl/outport_alloc_if.sv
// Request/grant/credit bundle between the input channels and one output-port allocator.
interface outport_alloc_if #(
    parameter int unsigned PORT_N = 5,
    parameter int unsigned VC_N   = 2,
    parameter int unsigned VC_W   = (VC_N > 1) ? $clog2(VC_N) : 1
);
    logic [PORT_N-1:0]      req_i;
    logic [PORT_N*VC_W-1:0] vch_i;
    logic                   flit_i;
    logic                   tail_i;
    logic [VC_N-1:0]        credit_i;
    logic [PORT_N-1:0]      grt_o;
    logic                   lck_o;
    logic [VC_W-1:0]        vch_o;
    logic [VC_N-1:0]        rdy_o;
    logic                   err_o;

    modport master (
        output req_i, vch_i, flit_i, tail_i, credit_i,
        input  grt_o, lck_o, vch_o, rdy_o, err_o
    );

    modport slave (
        input  req_i, vch_i, flit_i, tail_i, credit_i,
        output grt_o, lck_o, vch_o, rdy_o, err_o
    );
endinterface

// File: rtl/outport_alloc.sv
// Per-output-port wormhole switch allocator: round-robin grant held until the tail flit,
// with per-VC downstream credit counters driving rdy_o.
module outport_alloc #(
    parameter int unsigned ROUTERID   = 0,
    parameter int unsigned PCHID      = 0,
    parameter int unsigned PORT_N     = 5,
    parameter int unsigned VC_N       = 2,
    parameter int unsigned CREDIT_MAX = 4
) (
    input logic           clk,
    input logic           rst_n,
    outport_alloc_if.slave bus
);
    localparam int unsigned VC_W = (VC_N > 1) ? $clog2(VC_N) : 1;
    localparam int unsigned PW   = (PORT_N > 1) ? $clog2(PORT_N) : 1;
    localparam int unsigned CW   = $clog2(CREDIT_MAX + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PORT_N-1:0] grt_q;
    logic              lck_q;
    logic [VC_W-1:0]   vch_q;
    logic              err_q;
    logic [CW-1:0]     credit     [VC_N];
    logic [CW-1:0]     credit_nxt [VC_N];
    logic [VC_N-1:0]   rdy;
    logic              err_set;

    logic [PORT_N-1:0] eligible;
    logic              found;
    logic [PW-1:0]     win;
    logic [PW-1:0]     ptr_nxt;
    logic [VC_W-1:0]   win_vch;

    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < PORT_N; k++) begin
            eligible[k] = bus.req_i[k] && (credit[bus.vch_i[k*VC_W +: VC_W]] != '0);
        end
    end

    // Rotating search starting at ptr; first eligible input wins.
    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        win     = '0;
        ptr_nxt = ptr;
        win_vch = '0;
        for (int unsigned i = 0; i < PORT_N; i++) begin
            idx = (32'(ptr) + i) % PORT_N;
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win     = PW'(idx);
                ptr_nxt = PW'((idx + 1) % PORT_N);
                win_vch = bus.vch_i[idx*VC_W +: VC_W];
            end
        end
    end

    // Simultaneous return and consumption on a VC cancel out before any bound check.
    always_comb begin
        logic inc;
        logic dec;
        err_set = (state == IDLE) && bus.flit_i;
        for (int unsigned v = 0; v < VC_N; v++) begin
            credit_nxt[v] = credit[v];
            inc = bus.credit_i[v];
            dec = (state == LOCKED) && bus.flit_i && (vch_q == VC_W'(v));
            if (inc && !dec) begin
                if (credit[v] == CW'(CREDIT_MAX)) err_set = 1'b1;
                else                              credit_nxt[v] = credit[v] + 1'b1;
            end else if (dec && !inc) begin
                if (credit[v] == '0) err_set = 1'b1;
                else                 credit_nxt[v] = credit[v] - 1'b1;
            end
        end
    end

    always_comb begin
        rdy = '0;
        for (int unsigned v = 0; v < VC_N; v++) begin
            rdy[v] = (credit[v] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            grt_q <= '0;
            lck_q <= 1'b0;
            vch_q <= '0;
            err_q <= 1'b0;
            for (int unsigned v = 0; v < VC_N; v++) begin
                credit[v] <= CW'(CREDIT_MAX);
            end
        end else begin
            for (int unsigned v = 0; v < VC_N; v++) begin
                credit[v] <= credit_nxt[v];
            end
            if (err_set) err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (found) begin
                        grt_q <= PORT_N'(1) << win;
                        lck_q <= 1'b1;
                        vch_q <= win_vch;
                        ptr   <= ptr_nxt;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.flit_i && bus.tail_i) begin
                        grt_q <= '0;
                        lck_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grt_o = grt_q;
    assign bus.lck_o = lck_q;
    assign bus.vch_o = vch_q;
    assign bus.rdy_o = rdy;
    assign bus.err_o = err_q;

    grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grt_q))
        else $error("outport_alloc r%0d p%0d: grant not one-hot", ROUTERID, PCHID);
endmodule

// File: tb/tb_outport_alloc.sv
// Directed bench for outport_alloc: arbitration order, wormhole lock, credit bounds, reset.
module tb_outport_alloc;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    outport_alloc_if #(.PORT_N(5), .VC_N(2)) bus ();

    outport_alloc #(
        .ROUTERID(0), .PCHID(0), .PORT_N(5), .VC_N(2), .CREDIT_MAX(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_i    = '0;
        bus.vch_i    = '0;
        bus.flit_i   = 1'b0;
        bus.tail_i   = 1'b0;
        bus.credit_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    logic [4:0] rr_exp [6];

    initial begin
        checks   = 0;
        failures = 0;
        rr_exp   = '{5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00010, 5'b10000};

        // Reset values
        do_reset();
        check("rst_grt", 32'(bus.grt_o), 32'h0);
        check("rst_lck", 32'(bus.lck_o), 32'h0);
        check("rst_vch", 32'(bus.vch_o), 32'h0);
        check("rst_rdy", 32'(bus.rdy_o), 32'h3);
        check("rst_err", 32'(bus.err_o), 32'h0);

        // Single request from input 2 on VC1
        bus.req_i = 5'b00100; bus.vch_i = 5'b00100;
        step();
        check("t1_grt", 32'(bus.grt_o), 32'h04);
        check("t1_lck", 32'(bus.lck_o), 32'h1);
        check("t1_vch", 32'(bus.vch_o), 32'h1);
        idle_inputs();
        bus.flit_i = 1'b1; bus.tail_i = 1'b1;
        step();
        check("t1_rel_grt", 32'(bus.grt_o), 32'h0);
        check("t1_rel_lck", 32'(bus.lck_o), 32'h0);
        idle_inputs();

        // Round robin over inputs 0,1,4 with HEADTAIL packets, credit returned alongside
        do_reset();
        bus.req_i = 5'b10011;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t2_grant%0d", i), 32'(bus.grt_o), 32'(rr_exp[i]));
            check($sformatf("t2_lck%0d", i), 32'(bus.lck_o), 32'h1);
            bus.flit_i = 1'b1; bus.tail_i = 1'b1; bus.credit_i = 2'b01;
            step();
            check($sformatf("t2_idle%0d", i), 32'(bus.grt_o), 32'h0);
            bus.flit_i = 1'b0; bus.tail_i = 1'b0; bus.credit_i = 2'b00;
        end
        check("t2_err", 32'(bus.err_o), 32'h0);
        check("t2_rdy", 32'(bus.rdy_o), 32'h3);

        // Credit exhaustion on VC0
        do_reset();
        bus.req_i = 5'b00100;
        step();
        check("t3_grt", 32'(bus.grt_o), 32'h04);
        bus.req_i = '0;
        bus.flit_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("t3_rdy_f%0d", i), 32'(bus.rdy_o), (i == 4) ? 32'h2 : 32'h3);
        end
        check("t3_err_pre", 32'(bus.err_o), 32'h0);
        bus.tail_i = 1'b1;
        step();
        check("t3_err", 32'(bus.err_o), 32'h1);
        check("t3_rdy_hold", 32'(bus.rdy_o), 32'h2);
        check("t3_grt_rel", 32'(bus.grt_o), 32'h0);
        idle_inputs();

        // Wormhole hold with request dropped, release timing
        do_reset();
        bus.req_i = 5'b00001;
        step();
        check("t4_grt", 32'(bus.grt_o), 32'h01);
        bus.req_i = '0; bus.flit_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("t4_hold%0d", i), 32'(bus.grt_o), 32'h01);
            check($sformatf("t4_lck%0d", i), 32'(bus.lck_o), 32'h1);
        end
        bus.req_i = 5'b00010; bus.tail_i = 1'b1;
        step();
        check("t4_t1_grt", 32'(bus.grt_o), 32'h0);
        bus.flit_i = 1'b0; bus.tail_i = 1'b0;
        step();
        check("t4_t2_grt", 32'(bus.grt_o), 32'h02);
        check("t4_err", 32'(bus.err_o), 32'h0);
        idle_inputs();

        // Simultaneous consume and return keeps count at 2
        do_reset();
        bus.req_i = 5'b00001;
        step();
        bus.req_i = '0; bus.flit_i = 1'b1;
        step();
        step();
        bus.credit_i = 2'b01;
        step();
        bus.credit_i = 2'b00;
        step();
        check("t5_rdy_c1", 32'(bus.rdy_o), 32'h3);
        step();
        check("t5_rdy_c0", 32'(bus.rdy_o), 32'h2);
        check("t5_err0", 32'(bus.err_o), 32'h0);
        idle_inputs();

        // Return at CREDIT_MAX saturates and flags error
        do_reset();
        bus.credit_i = 2'b01;
        step();
        bus.credit_i = 2'b00;
        check("t5_sat_err", 32'(bus.err_o), 32'h1);
        check("t5_sat_rdy", 32'(bus.rdy_o), 32'h3);
        bus.req_i = 5'b00001;
        step();
        bus.req_i = '0; bus.flit_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.tail_i = (i == 4);
            step();
            check($sformatf("t5_sat_f%0d", i), 32'(bus.rdy_o), (i == 4) ? 32'h2 : 32'h3);
        end
        idle_inputs();

        // Zero-credit VC1 request is skipped in favour of VC0
        do_reset();
        bus.req_i = 5'b01000; bus.vch_i = 5'b01000;
        step();
        check("t6_grt3", 32'(bus.grt_o), 32'h08);
        bus.req_i = '0; bus.flit_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.tail_i = (i == 4);
            step();
        end
        check("t6_rdy", 32'(bus.rdy_o), 32'h1);
        bus.flit_i = 1'b0; bus.tail_i = 1'b0;
        bus.req_i = 5'b10001; bus.vch_i = 5'b10000;
        step();
        check("t6_skip_grt", 32'(bus.grt_o), 32'h01);
        check("t6_skip_vch", 32'(bus.vch_o), 32'h0);

        // Asynchronous reset while locked
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_arst_grt", 32'(bus.grt_o), 32'h0);
        check("t6_arst_lck", 32'(bus.lck_o), 32'h0);
        check("t6_arst_rdy", 32'(bus.rdy_o), 32'h3);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
